// File: rtl/smith_waterman_pe_if.sv
// Systolic link for one Smith-Waterman PE.
// slave = the PE; master = whatever drives it.
interface smith_waterman_pe_if #(
  parameter int SCORE_WIDTH = 10
);
  logic [SCORE_WIDTH-1:0] V_in;
  logic [SCORE_WIDTH-1:0] F_in;
  logic [1:0]             T_in;
  logic [1:0]             S_in;
  logic                   store_S_in;
  logic                   init_in;
  logic                   init_V_diag;
  logic                   init_E;
  logic                   init_V;
  logic [SCORE_WIDTH-1:0] V_out;
  logic [SCORE_WIDTH-1:0] E_out;
  logic [SCORE_WIDTH-1:0] F_out;
  logic [1:0]             S_out;
  logic [1:0]             T_out;
  logic                   store_S_out;
  logic                   init_out;

  modport master (
    output V_in, F_in, T_in, S_in,
    output store_S_in, init_in,
    output init_V_diag, init_E, init_V,
    input  V_out, E_out, F_out,
    input  S_out, T_out,
    input  store_S_out, init_out
  );

  modport slave (
    input  V_in, F_in, T_in, S_in,
    input  store_S_in, init_in,
    input  init_V_diag, init_E, init_V,
    output V_out, E_out, F_out,
    output S_out, T_out,
    output store_S_out, init_out
  );
endinterface

// File: rtl/smith_waterman_pe.sv
// One affine-gap Smith-Waterman cell per clock.
// Holds a read base; reference bases stream through.
module smith_waterman_pe #(
  parameter int SCORE_WIDTH = 10,
  parameter int MATCH       = 10,
  parameter int MISMATCH    = -2,
  parameter int GAP_OPEN    = -2,
  parameter int GAP_EXTEND  = -1
) (
  input logic                clk,
  input logic                rst,
  smith_waterman_pe_if.slave io
);

  typedef logic signed [SCORE_WIDTH-1:0] score_t;

  localparam score_t SUB_M = SCORE_WIDTH'(MATCH);
  localparam score_t SUB_X = SCORE_WIDTH'(MISMATCH);
  localparam score_t GAP_O = SCORE_WIDTH'(GAP_OPEN);
  localparam score_t GAP_E = SCORE_WIDTH'(GAP_EXTEND);

  function automatic score_t smax(
    input score_t a,
    input score_t b
  );
    return (a > b) ? a : b;
  endfunction

  score_t     v_q;
  score_t     e_q;
  score_t     f_q;
  score_t     vd_q;
  logic [1:0] s_q;
  logic [1:0] t_q;
  logic       st_q;
  logic       init_q;

  score_t v_in;
  score_t f_in;
  score_t d_op;
  score_t e_op;
  score_t v_op;
  score_t sub;
  score_t e_new;
  score_t f_new;
  score_t diag;
  score_t v_new;

  always_comb begin
    v_in  = $signed(io.V_in);
    f_in  = $signed(io.F_in);
    d_op  = io.init_V_diag ? '0 : vd_q;
    e_op  = io.init_E ? '0 : e_q;
    v_op  = io.init_V ? '0 : v_q;
    // compare against the old S even when a load is in flight
    sub   = (s_q == io.T_in) ? SUB_M : SUB_X;
    e_new = smax(v_op + GAP_O, e_op + GAP_E);
    f_new = smax(v_in + GAP_O, f_in + GAP_E);
    diag  = d_op + sub;
    v_new = smax(smax('0, diag),
                 smax(e_new, f_new));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      e_q    <= '0;
      f_q    <= '0;
      vd_q   <= '0;
      s_q    <= '0;
      t_q    <= '0;
      st_q   <= 1'b0;
      init_q <= 1'b0;
    end else begin
      t_q    <= io.T_in;
      st_q   <= io.store_S_in;
      init_q <= io.init_in;
      if (io.store_S_in) begin
        s_q <= io.S_in;
      end
      if (io.init_in) begin
        v_q  <= v_new;
        e_q  <= e_new;
        f_q  <= f_new;
        vd_q <= v_in;
      end else begin
        v_q  <= '0;
        e_q  <= '0;
        f_q  <= '0;
        vd_q <= '0;
      end
    end
  end

  assign io.V_out       = v_q;
  assign io.E_out       = e_q;
  assign io.F_out       = f_q;
  assign io.S_out       = s_q;
  assign io.T_out       = t_q;
  assign io.store_S_out = st_q;
  assign io.init_out    = init_q;

endmodule

// File: tb/tb_smith_waterman_pe.sv
// Bench for smith_waterman_pe: directed runs plus
// random vectors against an integer cell model.
module tb_smith_waterman_pe;

  localparam int W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  smith_waterman_pe_if #(.SCORE_WIDTH(W)) bus ();

  smith_waterman_pe #(.SCORE_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // model state, plain integers
  int mv, me, mf, mvd, ms, mt, mst, mini;

  int refseq[8] = '{0, 1, 0, 2, 0, 1, 3, 0};
  int run1_v[8] = '{10, 8, 10, 8, 10, 8, 7, 10};
  int run2_v[8] = '{0, 10, 8, 7, 6, 10, 8, 7};
  int run3_v[8] = '{8, 8, 8, 8, 8, 8, 20, 18};

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model(input int vin, input int fin,
                       input int t, input int s,
                       input int st, input int ini,
                       input int ivd, input int ie,
                       input int iv, input int r);
    int d, e, v, sub, en, fn;
    if (r != 0) begin
      mv = 0; me = 0; mf = 0; mvd = 0;
      ms = 0; mt = 0; mst = 0; mini = 0;
      return;
    end
    if (ini != 0) begin
      d   = (ivd != 0) ? 0 : mvd;
      e   = (ie != 0) ? 0 : me;
      v   = (iv != 0) ? 0 : mv;
      sub = (ms == t) ? 10 : -2;
      en  = imax(v - 2, e - 1);
      fn  = imax(vin - 2, fin - 1);
      mv  = imax(imax(0, d + sub), imax(en, fn));
      me  = en;
      mf  = fn;
      mvd = vin;
    end else begin
      mv = 0; me = 0; mf = 0; mvd = 0;
    end
    mt   = t;
    mst  = st;
    mini = ini;
    if (st != 0) ms = s;
  endtask

  task automatic check_all();
    chk("V_out", bus.V_out, W'(mv));
    chk("E_out", bus.E_out, W'(me));
    chk("F_out", bus.F_out, W'(mf));
    chk("S_out", bus.S_out, W'(ms));
    chk("T_out", bus.T_out, W'(mt));
    chk("store_S_out", bus.store_S_out, W'(mst));
    chk("init_out", bus.init_out, W'(mini));
  endtask

  task automatic step(input int vin, input int fin,
                      input int t, input int s,
                      input int st, input int ini,
                      input int ivd, input int ie,
                      input int iv, input int r);
    rst             = (r != 0);
    bus.V_in        = W'(vin);
    bus.F_in        = W'(fin);
    bus.T_in        = 2'(t);
    bus.S_in        = 2'(s);
    bus.store_S_in  = (st != 0);
    bus.init_in     = (ini != 0);
    bus.init_V_diag = (ivd != 0);
    bus.init_E      = (ie != 0);
    bus.init_V      = (iv != 0);
    model(vin, fin, t, s, st, ini, ivd, ie, iv, r);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic load(input int s, input int vin,
                      input int fin);
    step(vin, fin, 0, s, 1, 0, 0, 0, 0, 0);
    chk("load S_out", bus.S_out, W'(s));
    chk("load store_S_out", bus.store_S_out, W'(1));
    chk("load init_out", bus.init_out, W'(0));
  endtask

  task automatic stream(input string tag,
                        input int vin, input int fin,
                        input int fexp, input int vexp[8]);
    for (int k = 0; k < 8; k++) begin
      step(vin, fin, refseq[k], 0, 0, 1, 0, 0, 0, 0);
      chk({tag, " V"}, bus.V_out, W'(vexp[k]));
      chk({tag, " F"}, bus.F_out, W'(fexp));
      chk({tag, " T"}, bus.T_out, W'(refseq[k]));
      chk({tag, " init"}, bus.init_out, W'(1));
      chk({tag, " st"}, bus.store_S_out, W'(0));
    end
  endtask

  initial begin
    mv = 0; me = 0; mf = 0; mvd = 0;
    ms = 0; mt = 0; mst = 0; mini = 0;

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("reset V", bus.V_out, W'(0));
    chk("reset S", bus.S_out, W'(0));

    load(0, 0, 0);
    stream("run1", 0, 0, -1, run1_v);

    load(1, 0, 0);
    stream("run2", 0, 0, -1, run2_v);

    load(3, 10, -4);
    stream("run3", 10, -4, 8, run3_v);

    // boundary flags: init_V/init_E zero the gap operands
    load(0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("bnd first V", bus.V_out, W'(10));
    step(0, 0, 1, 0, 0, 1, 0, 1, 1, 0);
    chk("bnd init_V/E V", bus.V_out, W'(0));
    step(5, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
    chk("bnd init_V_diag V", bus.V_out, W'(10));

    // load and compute together: compute sees the old S
    step(0, 0, 0, 2, 1, 1, 0, 0, 0, 0);
    chk("old S compute V", bus.V_out, W'(10));
    chk("new S loaded", bus.S_out, W'(2));

    // reset mid-stream, then restream Run 1
    load(0, 0, 0);
    for (int k = 0; k < 4; k++)
      step(0, 0, refseq[k], 0, 0, 1, 0, 0, 0, 0);
    step(7, 3, 2, 1, 1, 1, 0, 0, 0, 1);
    chk("midrst V", bus.V_out, W'(0));
    chk("midrst E", bus.E_out, W'(0));
    chk("midrst F", bus.F_out, W'(0));
    chk("midrst S", bus.S_out, W'(0));
    chk("midrst T", bus.T_out, W'(0));
    chk("midrst init", bus.init_out, W'(0));
    load(0, 0, 0);
    stream("rerun1", 0, 0, -1, run1_v);

    // random vectors against the model
    for (int n = 0; n < 400; n++) begin
      int fin;
      fin = int'($urandom_range(100)) - 50;
      step(int'($urandom_range(200)), fin,
           int'($urandom_range(3)),
           int'($urandom_range(3)),
           int'($urandom_range(7) == 0),
           int'($urandom_range(7) != 0),
           int'($urandom_range(5) == 0),
           int'($urandom_range(5) == 0),
           int'($urandom_range(5) == 0),
           int'($urandom_range(60) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
